// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types and defaults for the run-length encoder
package rle_pkg;

  localparam int unsigned RLE_MAX_RUN    = 255;
  localparam int unsigned RLE_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND_CNT  = 2'd1,
    S_SEND_BYTE = 2'd2
  } ser_state_t;

  // 'byte' is a reserved word, so the run value field is called data
  typedef struct packed {
    logic [7:0] count;
    logic [7:0] data;
  } rle_pair_t;

endpackage

// File: rtl/rle_pair_fifo.sv
// rtl/rle_pair_fifo.sv - synchronous pair FIFO with registered read data
module rle_pair_fifo
  import rle_pkg::*;
#(
  parameter int unsigned DEPTH = RLE_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  rle_pair_t              push_data,
  input  logic                   pop,
  output rle_pair_t              rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  rle_pair_t        mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  rle_pair_t        rd_data_q, rd_data_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rd_data = rd_data_q;

  // a pop on a full FIFO frees the slot the same cycle, so the push may proceed
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // next-state for pointers, occupancy and the registered head
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - byte-stream run-length encoder emitting (count, byte) pairs
module rle_encoder
  import rle_pkg::*;
#(
  parameter int unsigned MAX_RUN    = RLE_MAX_RUN,
  parameter int unsigned FIFO_DEPTH = RLE_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       flush,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       overflow
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  MAX_CNT  = 8'(MAX_RUN);
  localparam logic [CW:0] DEPTH_W  = (CW+1)'(FIFO_DEPTH);

  logic [7:0]  cur_byte_q, cur_byte_d;
  logic [7:0]  cur_cnt_q, cur_cnt_d;
  logic        run_open_q, run_open_d;
  logic        flush_pend_q, flush_pend_d;
  logic        overflow_q, overflow_d;

  logic        push_req;
  logic        push_ok;
  rle_pair_t   push_pair;

  ser_state_t  ser_state_q;
  logic        out_valid_q;
  logic [7:0]  out_data_c;

  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  rle_pair_t   hold_pair;

  logic        hold_busy;
  logic        hold_release;
  logic [CW:0] occupancy;

  // run tracker: extend, close or open runs; a flush coinciding with a byte waits one cycle
  always_comb begin
    cur_byte_d   = cur_byte_q;
    cur_cnt_d    = cur_cnt_q;
    run_open_d   = run_open_q;
    flush_pend_d = 1'b0;
    push_req     = 1'b0;
    push_pair    = '{count: cur_cnt_q, data: cur_byte_q};
    if (flush_pend_q) begin
      push_req     = run_open_q;
      flush_pend_d = flush && in_valid;
      if (in_valid) begin
        cur_byte_d = in_data;
        cur_cnt_d  = 8'd1;
        run_open_d = 1'b1;
      end else begin
        run_open_d = 1'b0;
      end
    end else if (in_valid) begin
      flush_pend_d = flush;
      if (!run_open_q) begin
        cur_byte_d = in_data;
        cur_cnt_d  = 8'd1;
        run_open_d = 1'b1;
      end else if ((in_data == cur_byte_q) && (cur_cnt_q < MAX_CNT)) begin
        cur_cnt_d = cur_cnt_q + 8'd1;
      end else begin
        push_req   = 1'b1;
        cur_byte_d = in_data;
        cur_cnt_d  = 8'd1;
      end
    end else if (flush && run_open_q) begin
      push_req   = 1'b1;
      run_open_d = 1'b0;
    end
  end

  // the serializer's holding register counts toward pair capacity; finishing a data byte frees a slot
  always_comb begin
    hold_busy    = (ser_state_q != S_IDLE);
    hold_release = (ser_state_q == S_SEND_BYTE) && out_ready;
    occupancy    = {1'b0, fifo_count} + {{CW{1'b0}}, hold_busy};
    push_ok      = push_req && ((occupancy < DEPTH_W) || hold_release) && (!fifo_full || fifo_pop);
    overflow_d   = overflow_q || (push_req && !push_ok);
    fifo_pop     = !fifo_empty && ((ser_state_q == S_IDLE) || hold_release);
  end

  // run tracker and sticky overflow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_byte_q   <= 8'h00;
      cur_cnt_q    <= 8'h00;
      run_open_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cur_byte_q   <= cur_byte_d;
      cur_cnt_q    <= cur_cnt_d;
      run_open_q   <= run_open_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  rle_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_ok),
    .push_data (push_pair),
    .pop       (fifo_pop),
    .rd_data   (hold_pair),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // serializer: count byte then data byte per pair, chaining pairs without a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ser_state_q <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (ser_state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            ser_state_q <= S_SEND_CNT;
            out_valid_q <= 1'b1;
          end
        end
        S_SEND_CNT: begin
          if (out_ready) begin
            ser_state_q <= S_SEND_BYTE;
          end
        end
        S_SEND_BYTE: begin
          if (out_ready) begin
            if (!fifo_empty) begin
              ser_state_q <= S_SEND_CNT;
            end else begin
              ser_state_q <= S_IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          ser_state_q <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // output byte selected from the held pair by serializer state; zero when idle
  always_comb begin
    out_data_c = 8'h00;
    case (ser_state_q)
      S_SEND_CNT:  out_data_c = hold_pair.count;
      S_SEND_BYTE: out_data_c = hold_pair.data;
      default:     out_data_c = 8'h00;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_c;
  assign overflow  = overflow_q;
  assign busy      = run_open_q || flush_pend_q || !fifo_empty || (ser_state_q != S_IDLE);

endmodule

// File: tb/tb_rle_encoder.sv
// tb/tb_rle_encoder.sv - scoreboard bench for rle_encoder
module tb_rle_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  bit         rand_rdy = 1'b0;

  bit         m_open = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_cnt = 0;

  rle_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h expected nothing", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL out_byte got %h expected %h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic model_byte(input logic [7:0] b);
    if (!m_open) begin
      m_open = 1'b1;
      m_byte = b;
      m_cnt  = 1;
    end else if (b == m_byte && m_cnt < 255) begin
      m_cnt++;
    end else begin
      exp_q.push_back(8'(m_cnt));
      exp_q.push_back(m_byte);
      m_byte = b;
      m_cnt  = 1;
    end
  endtask

  task automatic model_flush();
    if (m_open) begin
      exp_q.push_back(8'(m_cnt));
      exp_q.push_back(m_byte);
    end
    m_open = 1'b0;
  endtask

  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic f);
    in_valid = v;
    in_data  = d;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    drive_cycle(1'b1, b, 1'b0);
  endtask

  task automatic do_flush();
    model_flush();
    drive_cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_byte_flush(input logic [7:0] b);
    model_byte(b);
    model_flush();
    drive_cycle(1'b1, b, 1'b1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    m_open = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d busy=%b expected pending=0 busy=0", name, exp_q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h busy=%b ovf=%b expected 0 00 0 0", out_valid, out_data, busy, overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] seq [6];
    seq = '{8'h55, 8'h55, 8'h66, 8'h66, 8'h61, 8'h66};
    foreach (seq[i]) send_byte(seq[i]);
    do_flush();
    wait_drain("basic");
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_overflow got %b expected 0", overflow);
    end
  endtask

  task automatic test_long_run();
    for (int i = 0; i < 300; i++) send_byte(8'h41);
    do_flush();
    wait_drain("long_run");
  endtask

  task automatic test_stall();
    bit seen;
    out_ready = 1'b0;
    repeat (3) send_byte(8'h7A);
    do_flush();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_valid_timeout got out_valid=0 expected 1");
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h03) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got v=%b d=%h expected v=1 d=03", i, out_valid, out_data);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, 8'(i % 2), 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1);
    repeat (3) drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got %b expected 1", overflow);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(8'(i % 2));
    end
    out_ready = 1'b1;
    wait_drain("overflow");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %b expected 1", overflow);
    end
    apply_reset();
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got %b expected 0", overflow);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush_same_cycle();
    send_byte(8'h10);
    send_byte(8'h10);
    send_byte_flush(8'h10);
    wait_drain("flush_same");
    do_flush();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL empty_flush got v=%b busy=%b expected 0 0", out_valid, busy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send_byte(8'($urandom_range(0, 2)));
      if ($urandom_range(0, 9) == 0) do_flush();
      repeat (3) drive_cycle(1'b0, 8'h00, 1'b0);
    end
    do_flush();
    wait_drain("random");
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL random_overflow got %b expected 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h3C);
    do_flush();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL resetmid_valid_timeout got out_valid=0 expected 1");
    end
    #2;
    reset = 1'b0;
    m_open = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL resetmid_async got v=%b busy=%b d=%h expected 0 0 00", out_valid, busy, out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL resetmid_quiet got busy=%b v=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_byte(8'h5A);
    send_byte(8'h5A);
    send_byte(8'hC3);
    do_flush();
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_run();
    test_stall();
    test_overflow();
    test_flush_same_cycle();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
